// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared 13-bit LFSR definitions (width, taps, seed, feedback, checker states) for generator and checker
package lfsr_pkg;
  localparam int LFSR_W = 13;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 13'h100D;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 13'h000F;
  typedef enum logic [1:0] {ST_SEED, ST_VERIFY, ST_LOCKED} chk_state_t;
  function automatic logic lfsr_fb(input logic [LFSR_W-1:0] s);
    return ^(s & LFSR_TAPS);
  endfunction
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], lfsr_fb(s)};
  endfunction
endpackage

// File: rtl/lfsr_checker.sv
// lfsr_checker: self-synchronising checker for the 13-bit LFSR stream with lock/loss tracking
// Ports: clock, reset (async, active-high), clear (sync clear of counters),
//   bit_in/bit_valid (serial stream), locked, error_pulse, err_count[ERR_W],
//   expected[13] (shadow register), bit_count[32].
// Macro LFSR_CHECKER_STATS_EN enables the locked-bit counter; otherwise bit_count is 0.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_MATCHES    = 16,
  parameter int LOSS_MISMATCHES = 4,
  parameter int ERR_W           = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              locked,
  output logic              error_pulse,
  output logic [ERR_W-1:0]  err_count,
  output logic [LFSR_W-1:0] expected,
  output logic [31:0]       bit_count
);
  localparam int MW = $clog2(LOCK_MATCHES + 1);
  localparam int LW = $clog2(LOSS_MISMATCHES + 1);

  chk_state_t        r_state;
  logic [LFSR_W-1:0] r_s;
  logic [3:0]        r_seed_cnt;
  logic [MW-1:0]     r_match_cnt;
  logic [LW-1:0]     r_miss_cnt;
  logic              r_locked;
  logic              r_error_pulse;
  logic [ERR_W-1:0]  r_err_count;
  logic              w_pred;
  logic              w_match;
  logic              w_miss;
  logic [LFSR_W-1:0] w_shift;

  assign w_pred  = lfsr_fb(r_s);
  assign w_match = bit_in == w_pred;
  assign w_shift = {r_s[LFSR_W-2:0], bit_in};
  assign w_miss  = bit_valid && r_state == ST_LOCKED && !w_match;

  assign locked      = r_locked;
  assign error_pulse = r_error_pulse;
  assign err_count   = r_err_count;
  assign expected    = r_s;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= ST_SEED;
      r_s           <= '0;
      r_seed_cnt    <= '0;
      r_match_cnt   <= '0;
      r_miss_cnt    <= '0;
      r_locked      <= 1'b0;
      r_error_pulse <= 1'b0;
    end else begin
      r_error_pulse <= 1'b0;
      if (bit_valid) begin
        case (r_state)
          ST_SEED: begin
            r_s <= w_shift;
            if (r_seed_cnt == 4'(LFSR_W - 1)) begin
              r_seed_cnt  <= '0;
              r_match_cnt <= '0;
              // an all-zero seed is the LFSR lock-up state, so reseed instead
              if (w_shift != '0) r_state <= ST_VERIFY;
            end else begin
              r_seed_cnt <= r_seed_cnt + 1'b1;
            end
          end
          ST_VERIFY: begin
            r_s <= w_shift;
            if (!w_match) begin
              r_state     <= ST_SEED;
              r_seed_cnt  <= '0;
              r_match_cnt <= '0;
            end else if (r_match_cnt == MW'(LOCK_MATCHES - 1)) begin
              r_state     <= ST_LOCKED;
              r_locked    <= 1'b1;
              r_match_cnt <= '0;
              r_miss_cnt  <= '0;
            end else begin
              r_match_cnt <= r_match_cnt + 1'b1;
            end
          end
          ST_LOCKED: begin
            // flywheel: the received bit never enters the shadow register
            r_s <= {r_s[LFSR_W-2:0], w_pred};
            if (w_match) begin
              r_miss_cnt <= '0;
            end else begin
              r_error_pulse <= 1'b1;
              if (r_miss_cnt == LW'(LOSS_MISMATCHES - 1)) begin
                r_state    <= ST_SEED;
                r_locked   <= 1'b0;
                r_seed_cnt <= '0;
                r_miss_cnt <= '0;
              end else begin
                r_miss_cnt <= r_miss_cnt + 1'b1;
              end
            end
          end
          default: begin
            r_state  <= ST_SEED;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_err_count <= '0;
    else if (clear) r_err_count <= '0;
    else if (w_miss && r_err_count != '1) r_err_count <= r_err_count + 1'b1;
  end

`ifdef LFSR_CHECKER_STATS_EN
  logic [31:0] r_bit_count;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_bit_count <= '0;
    else if (clear) r_bit_count <= '0;
    else if (bit_valid && r_state == ST_LOCKED && r_bit_count != '1) r_bit_count <= r_bit_count + 1'b1;
  end
  assign bit_count = r_bit_count;
`else
  assign bit_count = '0;
`endif
endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: table-driven and scoreboarded bench for lfsr_checker (default and ERR_W=4 instances)
module tb_lfsr_checker;
  logic        clock = 1'b0, reset = 1'b1, clear = 1'b0, bit_in = 1'b0, bit_valid = 1'b0;
  logic        locked, error_pulse, locked4, error_pulse4;
  logic [15:0] err_count;
  logic [3:0]  err_count4;
  logic [12:0] expected, expected4;
  logic [31:0] bit_count, bit_count4;

  always #5 clock = ~clock;

  lfsr_checker dut (
    .clock(clock), .reset(reset), .clear(clear), .bit_in(bit_in), .bit_valid(bit_valid),
    .locked(locked), .error_pulse(error_pulse), .err_count(err_count),
    .expected(expected), .bit_count(bit_count)
  );

  lfsr_checker #(.ERR_W(4)) dut4 (
    .clock(clock), .reset(reset), .clear(clear), .bit_in(bit_in), .bit_valid(bit_valid),
    .locked(locked4), .error_pulse(error_pulse4), .err_count(err_count4),
    .expected(expected4), .bit_count(bit_count4)
  );

  typedef struct {
    logic        lk;
    logic        ep;
    logic [15:0] ec;
    logic [3:0]  ec4;
    logic [12:0] ex;
    logic [31:0] bc;
  } exp_t;

  typedef struct {
    int   n;
    int   mode;
    logic lk;
    int   ec;
    int   ec4;
    int   pulses;
  } ph_t;

  exp_t        sb[$];
  ph_t         ph[15];
  int          n_chk = 0, n_pass = 0, p_cnt = 0;
  int          m_st, m_seed, m_match, m_miss;
  logic [12:0] m_s, g_s;
  logic        m_lk, m_ep;
  logic [15:0] m_e16;
  logic [3:0]  m_e4;
  logic [31:0] m_bc;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", nm, act, req);
  endtask

  task automatic model_reset();
    m_st = 0; m_s = '0; m_seed = 0; m_match = 0; m_miss = 0;
    m_lk = 1'b0; m_ep = 1'b0; m_e16 = '0; m_e4 = '0; m_bc = '0;
  endtask

  task automatic model_step(input logic b, input logic v, input logic c);
    logic pr;
    m_ep = 1'b0;
    if (v) begin
      pr = m_s[12] ^ m_s[3] ^ m_s[2] ^ m_s[0];
      if (m_st == 2) begin
`ifdef LFSR_CHECKER_STATS_EN
        if (m_bc != 32'hFFFF_FFFF) m_bc = m_bc + 1;
`endif
        m_s = {m_s[11:0], pr};
        if (b == pr) m_miss = 0;
        else begin
          m_ep = 1'b1;
          if (m_e16 != 16'hFFFF) m_e16 = m_e16 + 1;
          if (m_e4 != 4'hF) m_e4 = m_e4 + 1;
          m_miss++;
          if (m_miss == 4) begin m_st = 0; m_seed = 0; m_match = 0; m_miss = 0; end
        end
      end else if (m_st == 1) begin
        m_s = {m_s[11:0], b};
        if (b != pr) begin m_st = 0; m_seed = 0; m_match = 0; end
        else begin
          m_match++;
          if (m_match == 16) begin m_st = 2; m_match = 0; m_miss = 0; end
        end
      end else begin
        m_s = {m_s[11:0], b};
        m_seed++;
        if (m_seed == 13) begin
          m_seed = 0;
          if (m_s != 0) m_st = 1;
        end
      end
    end
    if (c) begin m_e16 = '0; m_e4 = '0; m_bc = '0; end
    m_lk = (m_st == 2);
  endtask

  task automatic gen(output logic b);
    b = g_s[12];
    g_s = {g_s[11:0], g_s[12] ^ g_s[3] ^ g_s[2] ^ g_s[0]};
  endtask

  task automatic cyc(input logic b, input logic v, input logic c);
    exp_t e;
    @(negedge clock);
    bit_in = b; bit_valid = v; clear = c;
    model_step(b, v, c);
    sb.push_back('{m_lk, m_ep, m_e16, m_e4, m_s, m_bc});
    @(posedge clock);
    #1;
    e = sb.pop_front();
    check("locked", locked, e.lk);
    check("error_pulse", error_pulse, e.ep);
    check("err_count", err_count, e.ec);
    check("err_count_w4", err_count4, e.ec4);
    check("expected", expected, e.ex);
    check("bit_count", bit_count, e.bc);
    if (error_pulse) p_cnt++;
  endtask

  task automatic do_reset();
    @(negedge clock);
    bit_valid = 1'b0; clear = 1'b0;
    #2 reset = 1'b1;
    model_reset();
    #1;
    check("rst_locked", locked, 0);
    check("rst_error_pulse", error_pulse, 0);
    check("rst_err_count", err_count, 0);
    check("rst_expected", expected, 0);
    check("rst_bit_count", bit_count, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    logic b, r;
    int   p0, lk_seen;
    g_s = 13'h000F;
    // {n, mode, locked, err16, err4, pulses}; modes: 0 good, 1 flipped, 2 idle,
    // 3 flip+good pairs, 4 clear only, 5 flipped with clear
    ph[0]  = '{10, 2, 1'b0, 0, 0, 0};
    ph[1]  = '{28, 0, 1'b0, 0, 0, 0};
    ph[2]  = '{1,  0, 1'b1, 0, 0, 0};
    ph[3]  = '{10, 0, 1'b1, 0, 0, 0};
    ph[4]  = '{1,  1, 1'b1, 1, 1, 1};
    ph[5]  = '{5,  0, 1'b1, 1, 1, 0};
    ph[6]  = '{4,  1, 1'b0, 5, 5, 4};
    ph[7]  = '{28, 0, 1'b0, 5, 5, 0};
    ph[8]  = '{1,  0, 1'b1, 5, 5, 0};
    ph[9]  = '{20, 3, 1'b1, 25, 15, 20};
    ph[10] = '{1,  5, 1'b1, 0, 0, 1};
    ph[11] = '{3,  0, 1'b1, 0, 0, 0};
    ph[12] = '{1,  1, 1'b1, 1, 1, 1};
    ph[13] = '{1,  4, 1'b1, 0, 0, 0};
    ph[14] = '{5,  2, 1'b1, 0, 0, 0};
    do_reset();
    for (int i = 0; i < 15; i++) begin
      p0 = p_cnt;
      for (int k = 0; k < ph[i].n; k++) begin
        r = 1'($urandom_range(0, 1));
        case (ph[i].mode)
          0: begin gen(b); cyc(b, 1'b1, 1'b0); end
          1: begin gen(b); cyc(~b, 1'b1, 1'b0); end
          2: cyc(r, 1'b0, 1'b0);
          3: begin gen(b); cyc(~b, 1'b1, 1'b0); gen(b); cyc(b, 1'b1, 1'b0); end
          4: cyc(r, 1'b0, 1'b1);
          default: begin gen(b); cyc(~b, 1'b1, 1'b1); end
        endcase
      end
      check($sformatf("ph%0d_locked", i), locked, ph[i].lk);
      check($sformatf("ph%0d_err_count", i), err_count, ph[i].ec);
      check($sformatf("ph%0d_err_count_w4", i), err_count4, ph[i].ec4);
      check($sformatf("ph%0d_pulses", i), p_cnt - p0, ph[i].pulses);
    end
    do_reset();
    repeat (28) begin gen(b); cyc(b, 1'b1, 1'b0); end
    check("relock_28", locked, 0);
    gen(b);
    cyc(b, 1'b1, 1'b0);
    check("relock_29", locked, 1);
    do_reset();
    lk_seen = 0;
    repeat (100) begin
      cyc(1'b0, 1'b1, 1'b0);
      if (locked) lk_seen++;
    end
    check("zero_stream_lock_seen", lk_seen, 0);
    check("zero_stream_expected", expected, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
